// File: rtl/np_bus_pkg.sv
// Shared picosoc iomem bus constants and the arbiter FSM state encoding.
// The peripheral address decoder reuses the bus widths defined here.
package np_bus_pkg;

    localparam int NP_IOMEM_AW = 32;
    localparam int NP_IOMEM_DW = 32;
    localparam int NP_IOMEM_SW = 4;

    localparam logic [NP_IOMEM_DW-1:0] NP_IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } np_arb_state_e;

endpackage

// File: rtl/np_iomem_arb_if.sv
// One picosoc iomem port: request fields, completion pulse and read data.
// The master modport is the requesting side and the slave modport is the responding side.
interface np_iomem_arb_if;

    logic                               valid;
    logic                               ready;
    logic [np_bus_pkg::NP_IOMEM_SW-1:0] wstrb;
    logic [np_bus_pkg::NP_IOMEM_AW-1:0] addr;
    logic [np_bus_pkg::NP_IOMEM_DW-1:0] wdata;
    logic [np_bus_pkg::NP_IOMEM_DW-1:0] rdata;

    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/np_iomem_arb_rr.sv
// Two-way round-robin grant selection.
// last_grant_reg remembers the master served most recently.
module np_rr_arb2 (
    input  logic       core_clock,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_grant_reg;

    // Reset value 1 makes master 0 the first winner under contention.
    always_ff @(posedge core_clock) begin
        if (!RST) begin
            last_grant_reg <= 1'b1;
        end else if (update) begin
            last_grant_reg <= served;
        end
    end

    assign gnt_valid = |req;
    assign gnt_id    = (req == 2'b11) ? ~last_grant_reg : req[1];

endmodule

// File: rtl/np_iomem_arb.sv
// Two-master iomem arbiter with round-robin grant and a per-transaction timeout.
// All outputs are registered; a transaction is IDLE -> REQ -> RESP -> GAP.
module np_iomem_arb
    import np_bus_pkg::*;
#(
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [NP_IOMEM_DW-1:0]  ERR_RDATA      = NP_IOMEM_ERR_RDATA
) (
    input  logic            core_clock,
    input  logic            RST,
    np_iomem_arb_if.slave   m0,
    np_iomem_arb_if.slave   m1,
    np_iomem_arb_if.master  s,
    output logic            timeout_irq,
    input  logic            timeout_clr,
    output logic            timeout_src
);

    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    np_arb_state_e state_reg, state_next;

    logic                   grant_id_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   s_valid_reg;
    logic [NP_IOMEM_AW-1:0] s_addr_reg;
    logic [NP_IOMEM_DW-1:0] s_wdata_reg;
    logic [NP_IOMEM_SW-1:0] s_wstrb_reg;
    logic                   timeout_irq_reg;
    logic                   timeout_src_reg;

    logic arb_valid;
    logic arb_id;
    logic do_grant;
    logic do_done;
    logic do_timeout;

    np_rr_arb2 u_rr (
        .core_clock (core_clock),
        .RST        (RST),
        .req        ({m1.valid, m0.valid}),
        .update     (state_reg == ST_RESP),
        .served     (grant_id_reg),
        .gnt_valid  (arb_valid),
        .gnt_id     (arb_id)
    );

    always_ff @(posedge core_clock) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_valid) begin
                    do_grant   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // A completion in the limit cycle still counts as a real response.
                if (s.ready) begin
                    do_done    = 1'b1;
                    state_next = ST_RESP;
                end else if (cnt_reg == CNT_LIMIT) begin
                    do_done    = 1'b1;
                    do_timeout = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clock) begin
        if (!RST) begin
            grant_id_reg <= 1'b0;
            cnt_reg      <= '0;
            s_valid_reg  <= 1'b0;
            s_addr_reg   <= '0;
            s_wdata_reg  <= '0;
            s_wstrb_reg  <= '0;
        end else if (do_grant) begin
            grant_id_reg <= arb_id;
            cnt_reg      <= '0;
            s_valid_reg  <= 1'b1;
            s_addr_reg   <= arb_id ? m1.addr  : m0.addr;
            s_wdata_reg  <= arb_id ? m1.wdata : m0.wdata;
            s_wstrb_reg  <= arb_id ? m1.wstrb : m0.wstrb;
        end else if (do_done) begin
            s_valid_reg  <= 1'b0;
        end else if (state_reg == ST_REQ) begin
            cnt_reg      <= cnt_reg + 1'b1;
        end
    end

    // A new timeout takes priority over a simultaneous clear.
    always_ff @(posedge core_clock) begin
        if (!RST) begin
            timeout_irq_reg <= 1'b0;
            timeout_src_reg <= 1'b0;
        end else if (do_timeout) begin
            timeout_irq_reg <= 1'b1;
            timeout_src_reg <= grant_id_reg;
        end else if (timeout_clr) begin
            timeout_irq_reg <= 1'b0;
        end
    end

    // Per-master response registers; the non-granted master always sees zeros.
    for (genvar gi = 0; gi < 2; gi++) begin : g_m
        logic                   ready_reg;
        logic [NP_IOMEM_DW-1:0] rdata_reg;

        always_ff @(posedge core_clock) begin
            if (!RST) begin
                ready_reg <= 1'b0;
                rdata_reg <= '0;
            end else if (do_done && (grant_id_reg == 1'(gi))) begin
                ready_reg <= 1'b1;
                rdata_reg <= do_timeout ? ERR_RDATA : s.rdata;
            end else begin
                ready_reg <= 1'b0;
                rdata_reg <= '0;
            end
        end
    end

    assign m0.ready = g_m[0].ready_reg;
    assign m0.rdata = g_m[0].rdata_reg;
    assign m1.ready = g_m[1].ready_reg;
    assign m1.rdata = g_m[1].rdata_reg;

    assign s.valid  = s_valid_reg;
    assign s.addr   = s_addr_reg;
    assign s.wdata  = s_wdata_reg;
    assign s.wstrb  = s_wstrb_reg;

    assign timeout_irq = timeout_irq_reg;
    assign timeout_src = timeout_src_reg;

endmodule

// File: tb/tb_np_iomem_arb.sv
// Randomized bench for np_iomem_arb against a transaction-level model of grant order,
// latency, forwarded fields, response data and the sticky timeout flag.
module tb_np_iomem_arb;

    localparam int T = 8;

    logic core_clock = 1'b0;
    logic RST        = 1'b0;
    logic timeout_clr = 1'b0;
    logic timeout_irq;
    logic timeout_src;

    np_iomem_arb_if m0_if ();
    np_iomem_arb_if m1_if ();
    np_iomem_arb_if s_if ();

    np_iomem_arb #(
        .TIMEOUT_CYCLES (T),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .core_clock  (core_clock),
        .RST         (RST),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .timeout_irq (timeout_irq),
        .timeout_clr (timeout_clr),
        .timeout_src (timeout_src)
    );

    always #5 core_clock = ~core_clock;

    int cyc = 0;
    always @(posedge core_clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model state: master served last, sticky flag and its source.
    bit last_grant_m = 1'b1;
    bit irq_m        = 1'b0;
    bit src_m        = 1'b0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge core_clock);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
        m1_if.valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
        s_if.ready  = 1'b0; s_if.rdata = '0;
        timeout_clr = 1'b0;
    endtask

    // Starts in an IDLE cycle ("cycle 0"), returns at the next IDLE cycle.
    // lat: cycle (1-based) of s_ready; lat > T means the slave never answers.
    task automatic run_txn(input string tag, input bit v0, input bit v1,
                           input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] s0,
                           input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] s1,
                           input int lat, input logic [31:0] rd, input bit keep,
                           input bit drop, input int clr_cyc, output int rise_abs);
        int win, exp_sv, r, sv_cnt, first_sv, ready_cyc;
        int bad_fwd, bad_other, bad_irq, extra_ready;
        bit to;
        logic own_rdy, oth_rdy, src_seen;
        logic [31:0] exp_rd, got_rd, own_rd, oth_rd, ea, ew;
        logic [3:0] es;

        win    = (v0 && v1) ? (last_grant_m ? 0 : 1) : (v1 ? 1 : 0);
        to     = (lat > T);
        exp_sv = to ? T : lat;
        r      = exp_sv + 1;
        exp_rd = to ? 32'hDEAD_BEEF : rd;
        ea = (win == 1) ? a1 : a0;
        ew = (win == 1) ? w1 : w0;
        es = (win == 1) ? s1 : s0;

        m0_if.valid = v0; m0_if.addr = a0; m0_if.wdata = w0; m0_if.wstrb = s0;
        m1_if.valid = v1; m1_if.addr = a1; m1_if.wdata = w1; m1_if.wstrb = s1;
        s_if.ready  = 1'($urandom_range(0, 1));
        s_if.rdata  = $urandom;
        timeout_clr = 1'b0;
        next_cycle();

        sv_cnt = 0; first_sv = -1; ready_cyc = -1; rise_abs = -1;
        bad_fwd = 0; bad_other = 0; bad_irq = 0; extra_ready = 0;
        got_rd = '0; src_seen = 1'b0;
        for (int c = 1; c <= T + 3; c++) begin
            if (drop && c == 2) begin
                m0_if.valid = 1'b0;
                m1_if.valid = 1'b0;
            end
            if (c == r + 1 && !keep) begin
                m0_if.valid = 1'b0;
                m1_if.valid = 1'b0;
            end
            s_if.ready  = (c == lat) || (c > exp_sv && $urandom_range(0, 1) == 1);
            s_if.rdata  = (c == lat) ? rd : $urandom;
            timeout_clr = (c == clr_cyc);
            @(negedge core_clock);
            if (s_if.valid === 1'b1) begin
                sv_cnt++;
                if (first_sv < 0) begin
                    first_sv = c;
                    rise_abs = cyc;
                end
                if (s_if.addr !== ea || s_if.wdata !== ew || s_if.wstrb !== es) bad_fwd++;
            end
            if (timeout_irq !== irq_m) bad_irq++;
            own_rdy = (win == 1) ? m1_if.ready : m0_if.ready;
            own_rd  = (win == 1) ? m1_if.rdata : m0_if.rdata;
            oth_rdy = (win == 1) ? m0_if.ready : m1_if.ready;
            oth_rd  = (win == 1) ? m0_if.rdata : m1_if.rdata;
            if (oth_rdy !== 1'b0 || oth_rd !== 32'h0) bad_other++;
            if (own_rdy === 1'b1) begin
                if (ready_cyc < 0) begin
                    ready_cyc = c;
                    got_rd    = own_rd;
                    src_seen  = timeout_src;
                end else begin
                    extra_ready++;
                end
            end
            if (own_rdy !== 1'b0 && own_rdy !== 1'b1) extra_ready++;
            // Effect of the edge that ends cycle c.
            if (to && c == exp_sv) begin
                irq_m = 1'b1;
                src_m = win[0];
            end else if (c == clr_cyc) begin
                irq_m = 1'b0;
            end
            next_cycle();
            if (c == r + 1) break;
        end
        timeout_clr = 1'b0;
        s_if.ready  = 1'b0;
        last_grant_m = win[0];

        checks++;
        if (first_sv !== 1) begin
            errors++; $display("FAIL %s s_valid_first_cycle: got %0d expected 1", tag, first_sv);
        end
        checks++;
        if (sv_cnt !== exp_sv) begin
            errors++; $display("FAIL %s s_valid_cycles: got %0d expected %0d", tag, sv_cnt, exp_sv);
        end
        checks++;
        if (bad_fwd !== 0) begin
            errors++; $display("FAIL %s s_fields (master %0d): %0d bad cycles expected 0", tag, win, bad_fwd);
        end
        checks++;
        if (ready_cyc !== r) begin
            errors++; $display("FAIL %s m%0d_ready_cycle: got %0d expected %0d", tag, win, ready_cyc, r);
        end
        checks++;
        if (got_rd !== exp_rd) begin
            errors++; $display("FAIL %s m%0d_rdata: got %08h expected %08h", tag, win, got_rd, exp_rd);
        end
        checks++;
        if (extra_ready !== 0) begin
            errors++; $display("FAIL %s m%0d_ready_single_pulse: %0d extra cycles expected 0", tag, win, extra_ready);
        end
        checks++;
        if (bad_other !== 0) begin
            errors++; $display("FAIL %s other_master_quiet: %0d bad cycles expected 0", tag, bad_other);
        end
        checks++;
        if (bad_irq !== 0) begin
            errors++; $display("FAIL %s timeout_irq_track: %0d bad cycles expected 0", tag, bad_irq);
        end
        checks++;
        if (src_seen !== src_m) begin
            errors++; $display("FAIL %s timeout_src: got %0b expected %0b", tag, src_seen, src_m);
        end
        $display("txn %s: master %0d lat %0d sv_cycles %0d ready_cycle %0d rdata %08h irq %0b",
                 tag, win, lat, sv_cnt, ready_cyc, got_rd, irq_m);
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge core_clock);
        checks++; if (s_if.valid !== 1'b0)  begin errors++; $display("FAIL reset s_valid: got %0b expected 0", s_if.valid); end
        checks++; if (s_if.addr !== 32'h0)  begin errors++; $display("FAIL reset s_addr: got %08h expected 0", s_if.addr); end
        checks++; if (s_if.wdata !== 32'h0) begin errors++; $display("FAIL reset s_wdata: got %08h expected 0", s_if.wdata); end
        checks++; if (s_if.wstrb !== 4'h0)  begin errors++; $display("FAIL reset s_wstrb: got %0h expected 0", s_if.wstrb); end
        checks++; if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) begin
            errors++; $display("FAIL reset m_ready: got %0b%0b expected 00", m1_if.ready, m0_if.ready);
        end
        checks++; if (m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin
            errors++; $display("FAIL reset m_rdata: got %08h/%08h expected 0", m0_if.rdata, m1_if.rdata);
        end
        checks++; if (timeout_irq !== 1'b0) begin errors++; $display("FAIL reset timeout_irq: got %0b expected 0", timeout_irq); end
        checks++; if (timeout_src !== 1'b0) begin errors++; $display("FAIL reset timeout_src: got %0b expected 0", timeout_src); end
        $display("txn reset: outputs sampled with RST low");
        next_cycle();
        RST = 1'b1;
        last_grant_m = 1'b1; irq_m = 1'b0; src_m = 1'b0;
    endtask

    task automatic test_contention();
        int rise [4];
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("contention%0d", i), 1'b1, 1'b1,
                    32'h0200_0100, 32'h0, 4'h0, 32'h0200_0200, 32'h0, 4'h0,
                    1, $urandom, 1'b1, 1'b0, 0, rise[i]);
        end
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rise[i] - rise[i-1] < 4) begin
                errors++;
                $display("FAIL contention s_valid_spacing%0d: got %0d cycles required >=4", i, rise[i] - rise[i-1]);
            end
        end
    endtask

    task automatic test_single_read();
        int rise;
        run_txn("single_read", 1'b1, 1'b0, 32'h0200_0004, $urandom, 4'h0,
                $urandom, $urandom, 4'h0, 3, 32'h1234_5678, 1'b0, 1'b0, 0, rise);
    endtask

    task automatic test_write_fwd();
        int rise;
        run_txn("write_fwd", 1'b0, 1'b1, $urandom, $urandom, 4'hF,
                32'h0300_0000, 32'hAABB_CCDD, 4'b0011, int'($urandom_range(1, 4)),
                $urandom, 1'b0, 1'b0, 0, rise);
    endtask

    task automatic test_timeout();
        int rise;
        run_txn("timeout", 1'b0, 1'b1, $urandom, $urandom, 4'h0,
                32'h0300_0010, $urandom, 4'h0, 1000, $urandom, 1'b0, 1'b0, 0, rise);
        timeout_clr = 1'b1;
        @(negedge core_clock);
        checks++;
        if (timeout_irq !== 1'b1) begin
            errors++; $display("FAIL timeout irq_before_clr_edge: got %0b expected 1", timeout_irq);
        end
        next_cycle();
        timeout_clr = 1'b0;
        irq_m = 1'b0;
        @(negedge core_clock);
        checks++;
        if (timeout_irq !== 1'b0) begin
            errors++; $display("FAIL timeout irq_after_clr: got %0b expected 0", timeout_irq);
        end
        $display("txn timeout_clr: irq %0b", timeout_irq);
        next_cycle();
    endtask

    task automatic test_boundary();
        int rise;
        run_txn("ready_at_limit", 1'b1, 1'b0, 32'h0200_0040, $urandom, 4'h0,
                $urandom, $urandom, 4'h0, T, 32'h0BAD_F00D, 1'b0, 1'b0, 0, rise);
        run_txn("timeout_m0", 1'b1, 1'b0, 32'h0200_0044, $urandom, 4'h0,
                $urandom, $urandom, 4'h0, 1000, $urandom, 1'b0, 1'b0, 0, rise);
        run_txn("clr_with_timeout", 1'b0, 1'b1, $urandom, $urandom, 4'h0,
                32'h0300_0048, $urandom, 4'h0, 1000, $urandom, 1'b0, 1'b0, T, rise);
    endtask

    task automatic test_random();
        int rise, k, lat, clr;
        for (int i = 0; i < 20; i++) begin
            k   = int'($urandom_range(1, 3));
            lat = int'($urandom_range(1, T + 2));
            clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T)) : 0;
            run_txn($sformatf("random%0d", i), k[0], k[1],
                    $urandom, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom),
                    lat, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), clr, rise);
        end
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        int rise, bad;
        m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0080; m1_if.wstrb = 4'h0;
        next_cycle();
        @(negedge core_clock);
        checks++;
        if (s_if.valid !== 1'b1) begin
            errors++; $display("FAIL reset_mid s_valid_before: got %0b expected 1", s_if.valid);
        end
        next_cycle();
        RST = 1'b0;
        next_cycle();
        RST = 1'b1;
        m1_if.valid = 1'b0;
        last_grant_m = 1'b1; irq_m = 1'b0; src_m = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge core_clock);
            if (s_if.valid !== 1'b0 || m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL reset_mid dropped_txn: %0d active cycles expected 0", bad);
        end
        $display("txn reset_mid: transaction dropped, %0d active cycles", bad);
        run_txn("after_reset", 1'b1, 1'b1, 32'h0200_00C0, $urandom, 4'h0,
                32'h0300_00C0, $urandom, 4'h0, 2, $urandom, 1'b0, 1'b0, 0, rise);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_write_fwd();
        test_timeout();
        test_boundary();
        test_random();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
